// File: rtl/radio_tx_gain_ramp_if.sv
// Handshake bundle between the Tx controller and the gain ramp generator.
interface radio_tx_gain_ramp_if #(
    parameter int GAIN_W = 6,
    parameter int STEP_W = 4,
    parameter int CNT_W  = 8
);
    logic              tx_start;
    logic              tx_en;
    logic [GAIN_W-1:0] target_gain;
    logic [STEP_W-1:0] gain_step;
    logic [CNT_W-1:0]  step_interval;
    logic [CNT_W-1:0]  start_delay;
    logic [GAIN_W-1:0] user_Tx_gain;
    logic              ramp_busy;
    logic              ramp_done;
    logic              tx_active;

    modport master (
        output tx_start, tx_en, target_gain, gain_step,
        output step_interval, start_delay,
        input  user_Tx_gain, ramp_busy, ramp_done, tx_active
    );

    modport slave (
        input  tx_start, tx_en, target_gain, gain_step,
        input  step_interval, start_delay,
        output user_Tx_gain, ramp_busy, ramp_done, tx_active
    );
endinterface

// File: rtl/radio_tx_gain_ramp.sv
// Tx gain ramp: delay, then stepped ramp 0->target, hold while TxEn is high.
// Optional RAMP_DOWN_EN adds a stepped ramp back to 0 on TxEn fall.
module radio_tx_gain_ramp #(
    parameter int GAIN_W = 6,
    parameter int STEP_W = 4,
    parameter int CNT_W  = 8
) (
    input logic                  converter_clock_in,
    input logic                  converter_reset_n,
    radio_tx_gain_ramp_if.slave  bus
);
    localparam int SW = GAIN_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RAMP,
`ifdef RAMP_DOWN_EN
        RAMPDN,
`endif
        HOLD
    } state_t;

    state_t state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d, tgt_q, tgt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  itv_q, itv_d, dly_q, dly_d, icnt_q, icnt_d;
    logic              start_q, busy_q, busy_d, done_q, done_d;
    logic              act_q, act_d, start_evt;
    logic [SW-1:0]     sum;
    logic [GAIN_W-1:0] up;
`ifdef RAMP_DOWN_EN
    logic [GAIN_W-1:0] dn;
`endif

    always_ff @(posedge converter_clock_in) begin
        if (!converter_reset_n) begin
            state_q <= IDLE;
            gain_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            itv_q   <= '0;
            dly_q   <= '0;
            icnt_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            itv_q   <= itv_d;
            dly_q   <= dly_d;
            icnt_q  <= icnt_d;
            start_q <= bus.tx_start;
            busy_q  <= busy_d;
            done_q  <= done_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gain_d    = gain_q;
        tgt_d     = tgt_q;
        step_d    = step_q;
        itv_d     = itv_q;
        dly_d     = dly_q;
        icnt_d    = icnt_q;
        done_d    = 1'b0;
        start_evt = bus.tx_start & ~start_q;
        // One extra bit so a step near full scale clamps instead of wrapping
        sum = {1'b0, gain_q} + SW'(step_q);
        up  = (sum > {1'b0, tgt_q}) ? tgt_q : sum[GAIN_W-1:0];
`ifdef RAMP_DOWN_EN
        dn  = (gain_q > GAIN_W'(step_q)) ? gain_q - GAIN_W'(step_q) : '0;
`endif
        unique case (state_q)
            IDLE: begin
                gain_d = '0;
                if (start_evt && bus.tx_en) begin
                    tgt_d  = bus.target_gain;
                    step_d = (bus.gain_step == '0) ? STEP_W'(1) : bus.gain_step;
                    itv_d  = bus.step_interval;
                    if (bus.start_delay != '0) begin
                        state_d = DELAY;
                        dly_d   = bus.start_delay - 1'b1;
                    end else begin
                        state_d = RAMP;
                        icnt_d  = bus.step_interval;
                    end
                end
            end
            DELAY: begin
                if (!bus.tx_en) begin
                    state_d = IDLE;
                    gain_d  = '0;
                end else if (dly_q == '0) begin
                    state_d = RAMP;
                    icnt_d  = itv_q;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            RAMP: begin
                if (!bus.tx_en) begin
`ifdef RAMP_DOWN_EN
                    state_d = RAMPDN;
                    icnt_d  = itv_q;
`else
                    state_d = IDLE;
                    gain_d  = '0;
`endif
                end else if (gain_q == tgt_q) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end else if (icnt_q == '0) begin
                    gain_d = up;
                    icnt_d = itv_q;
                    if (up == tgt_q) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end
                end else begin
                    icnt_d = icnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (!bus.tx_en) begin
`ifdef RAMP_DOWN_EN
                    state_d = RAMPDN;
                    icnt_d  = itv_q;
`else
                    state_d = IDLE;
                    gain_d  = '0;
`endif
                end
            end
`ifdef RAMP_DOWN_EN
            RAMPDN: begin
                if (icnt_q == '0) begin
                    gain_d = dn;
                    icnt_d = itv_q;
                    if (dn == '0) state_d = IDLE;
                end else begin
                    icnt_d = icnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                gain_d  = '0;
            end
        endcase
        busy_d = (state_d == DELAY) || (state_d == RAMP);
`ifdef RAMP_DOWN_EN
        busy_d = busy_d || (state_d == RAMPDN);
`endif
        act_d = (state_d == HOLD);
    end

    assign bus.user_Tx_gain = gain_q;
    assign bus.ramp_busy    = busy_q;
    assign bus.ramp_done    = done_q;
    assign bus.tx_active    = act_q;
endmodule

// File: tb/tb_radio_tx_gain_ramp.sv
// Bench for radio_tx_gain_ramp: per-cycle trace model plus literal spot checks.
// Covers both builds; RAMP_DOWN_EN selects the ramp-down expectations.
module tb_radio_tx_gain_ramp;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   ndone = 0;
    bit   chk_en = 1'b0;

    typedef struct {
        int g;
        bit b;
        bit d;
        bit a;
        int ph;
    } smp_t;

    smp_t q[$];
    smp_t cur;
    int   m_step, m_itv;
    int   cg[100];
    int   cd[100];

    radio_tx_gain_ramp_if bus ();

    radio_tx_gain_ramp dut (
        .converter_clock_in (clk),
        .converter_reset_n  (rst_n),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void push(int g, bit b, bit d, bit a, int ph);
        smp_t s;
        s.g = g; s.b = b; s.d = d; s.a = a; s.ph = ph;
        q.push_back(s);
    endfunction

    // Expected trace from the start edge onward, one entry per clock
    function automatic void gen(int tgt, int step, int itv, int dly);
        int g = 0;
        m_step = (step == 0) ? 1 : step;
        m_itv  = itv;
        repeat (dly) push(0, 1, 0, 0, 1);
        if (tgt == 0) begin
            push(0, 1, 0, 0, 2);
            push(0, 0, 1, 1, 3);
            return;
        end
        while (1) begin
            repeat (itv + 1) push(g, 1, 0, 0, 2);
            g = (g + m_step > tgt) ? tgt : g + m_step;
            if (g == tgt) begin
                push(g, 0, 1, 1, 3);
                break;
            end
        end
    endfunction

    function automatic void abort();
        int g = cur.g;
        q.delete();
`ifdef RAMP_DOWN_EN
        if (cur.ph == 2 || cur.ph == 3) begin
            while (1) begin
                repeat (m_itv + 1) push(g, 1, 0, 0, 4);
                g = (g > m_step) ? g - m_step : 0;
                if (g == 0) break;
            end
        end
`else
        g = 0;
`endif
        push(g, 0, 0, 0, 0);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0) cur = q.pop_front();
            else cur.d = 1'b0;
            chk("gain", bus.user_Tx_gain, cur.g);
            chk("busy", bus.ramp_busy, int'(cur.b));
            chk("done", bus.ramp_done, int'(cur.d));
            chk("active", bus.tx_active, int'(cur.a));
        end
        if (bus.ramp_done === 1'b1) ndone++;
    end

    task automatic step_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start(input int tgt, input int step, input int itv, input int dly);
        bus.tx_start = 1'b0;
        step_cyc(1);
        bus.target_gain   = 6'(tgt);
        bus.gain_step     = 4'(step);
        bus.step_interval = 8'(itv);
        bus.start_delay   = 8'(dly);
        bus.tx_en    = 1'b1;
        bus.tx_start = 1'b1;
        gen(tgt, step, itv, dly);
    endtask

    task automatic cap(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            cg[i] = int'(bus.user_Tx_gain);
            cd[i] = int'(bus.ramp_done);
            #1;
        end
    endtask

    task automatic wait_g(input int g, input int lim);
        for (int i = 0; i < lim && cur.g != g; i++) step_cyc(1);
        chk("wait_gain", cur.g, g);
    endtask

    task automatic wait_empty(input int lim);
        for (int i = 0; i < lim && q.size() > 0; i++) step_cyc(1);
        chk("wait_trace", q.size(), 0);
    endtask

    task automatic drop();
        bus.tx_en = 1'b0;
        abort();
    endtask

    initial begin
        int s;
        cur = '{g: 0, b: 0, d: 0, a: 0, ph: 0};
        rst_n = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_en = 1'b0;
        bus.target_gain = '0;
        bus.gain_step = '0;
        bus.step_interval = '0;
        bus.start_delay = '0;
        @(posedge clk);
        chk_en = 1'b1;
        step_cyc(2);
        rst_n = 1'b1;
        chk("rst_gain", bus.user_Tx_gain, 0);
        chk("rst_busy", bus.ramp_busy, 0);
        chk("rst_done", bus.ramp_done, 0);
        chk("rst_active", bus.tx_active, 0);

        // Full ramp with delay and interval
        start(40, 8, 3, 2);
        cap(24);
        chk("t1_g6", cg[6], 0);
        chk("t1_g7", cg[7], 8);
        chk("t1_g22", cg[22], 32);
        chk("t1_g23", cg[23], 40);
        chk("t1_d23", cd[23], 1);
        s = 0;
        for (int i = 1; i <= 24; i++) s += cd[i];
        chk("t1_ndone", s, 1);
        bus.target_gain = 6'd5;
        bus.gain_step = 4'd1;
        step_cyc(5);
        chk("t1_hold", bus.user_Tx_gain, 40);
        drop();
        wait_empty(200);

        // No overshoot, no wrap
        start(20, 8, 0, 0);
        cap(5);
        chk("t2_g2", cg[2], 8);
        chk("t2_g3", cg[3], 16);
        chk("t2_g4", cg[4], 20);
        chk("t2_d4", cd[4], 1);
        drop();
        wait_empty(200);
        start(63, 15, 0, 0);
        cap(7);
        chk("t2b_g2", cg[2], 15);
        chk("t2b_g5", cg[5], 60);
        chk("t2b_g6", cg[6], 63);
        chk("t2b_d6", cd[6], 1);
        drop();
        wait_empty(200);

        // TxEn fall mid-ramp
        start(40, 8, 1, 0);
        wait_g(16, 100);
        drop();
        cap(6);
`ifdef RAMP_DOWN_EN
        chk("t3_g2", cg[2], 16);
        chk("t3_g3", cg[3], 8);
        chk("t3_g4", cg[4], 8);
        chk("t3_g5", cg[5], 0);
`else
        chk("t3_g1", cg[1], 0);
`endif
        s = 0;
        for (int i = 1; i <= 6; i++) s += cd[i];
        chk("t3_nodone", s, 0);
        wait_empty(200);

        // TxEn fall during delay
        start(10, 2, 0, 5);
        step_cyc(2);
        drop();
        cap(2);
        chk("t3b_g1", cg[1], 0);
        chk("t3b_busy", bus.ramp_busy, 0);
        wait_empty(50);

        // Start with TxEn low is ignored
        bus.tx_start = 1'b0;
        step_cyc(1);
        bus.tx_start = 1'b1;
        step_cyc(3);
        chk("noen_busy", bus.ramp_busy, 0);

        // Held start and a second pulse in HOLD give one ramp
        ndone = 0;
        start(16, 8, 0, 0);
        step_cyc(50);
        bus.tx_start = 1'b0;
        step_cyc(2);
        bus.tx_start = 1'b1;
        step_cyc(2);
        bus.tx_start = 1'b0;
        step_cyc(2);
        chk("t4_ndone", ndone, 1);
        chk("t4_gain", bus.user_Tx_gain, 16);
        drop();
        wait_empty(200);
        start(3, 0, 0, 0);
        cap(5);
        chk("t4_s0_g2", cg[2], 1);
        chk("t4_s0_g3", cg[3], 2);
        chk("t4_s0_g4", cg[4], 3);
        drop();
        wait_empty(200);

        // Reset mid-ramp
        start(40, 8, 1, 1);
        wait_g(24, 100);
        rst_n = 1'b0;
        bus.tx_start = 1'b0;
        q.delete();
        push(0, 0, 0, 0, 0);
        step_cyc(1);
        chk("t5_gain", bus.user_Tx_gain, 0);
        chk("t5_busy", bus.ramp_busy, 0);
        chk("t5_active", bus.tx_active, 0);
        rst_n = 1'b1;
        start(12, 4, 0, 0);
        wait_empty(100);
        chk("t5_regain", bus.user_Tx_gain, 12);
        chk("t5_reactive", bus.tx_active, 1);
        drop();
        wait_empty(200);

        // Target zero
        start(0, 4, 2, 3);
        cap(7);
        chk("t6_d5", cd[5], 1);
        chk("t6_d4", cd[4], 0);
        chk("t6_g5", cg[5], 0);
        chk("t6_active", bus.tx_active, 1);
        drop();
        wait_empty(200);
        step_cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/radio_tx_gain_ramp.md
Name: radio_tx_gain_ramp

Overview:
Upstream companion to the radio bridge. It generates the 6-bit Tx gain word that the bridge muxes onto radio_B during Tx. On each Tx start it waits a programmable delay, then ramps gain from 0 to a target in fixed steps at a fixed cadence, which avoids PA spectral splatter. The gain returns to 0 when TxEn drops. Clocked in the converter clock domain, alongside the bridge registers.

Parameters:
GAIN_W, 6, gain word width; matches user_Tx_gain.
STEP_W, 4, gain step width.
CNT_W, 8, width of the delay and interval counters.

Ports:
converter_clock_in  input  1  converter clock; all logic on its rising edge.
converter_reset_n  input  1  synchronous, active-low reset.
tx_start  input  1  Tx start request, level-sensitive; rising edge detected internally.
tx_en  input  1  controller TxEn level.
target_gain  input  GAIN_W  final Tx gain; latched at start.
gain_step  input  STEP_W  increment per step; latched at start; 0 is treated as 1.
step_interval  input  CNT_W  the step period is step_interval+1 cycles; latched at start.
start_delay  input  CNT_W  cycles spent in DELAY before ramping; latched at start.
user_Tx_gain  output  GAIN_W  registered gain word to the bridge.
ramp_busy  output  1  high in DELAY, RAMP or RAMPDN.
ramp_done  output  1  one-cycle pulse when the gain reaches target.
tx_active  output  1  high in HOLD.

Behaviour:
- Reset (converter_reset_n low at a clock edge):
  - state IDLE.
  - user_Tx_gain=0, ramp_busy=0, ramp_done=0, tx_active=0.
  - Edge-detect register and counters cleared.
  - Reset overrides everything, including mid-ramp.
- Start detection: start_evt = tx_start high AND its previous sampled value low. start_evt is honoured only in IDLE and only with tx_en=1. It is ignored in every other state.
- IDLE: gain held at 0. On start_evt:
  - Latch target, step, interval and delay.
  - If delay≠0: go to DELAY with dly_cnt=delay-1.
  - Else go to RAMP with int_cnt=interval.
- DELAY: decrement dly_cnt each cycle. When dly_cnt==0: go to RAMP and load int_cnt=interval.
- RAMP:
  - Decrement int_cnt each cycle.
  - When int_cnt==0: gain <= min(gain+step, target), computed at GAIN_W+1 bits so it cannot wrap at 63; reload int_cnt.
  - When the new gain equals target: go to HOLD and pulse ramp_done in the cycle user_Tx_gain first shows the target.
  - The first increment lands interval+1 cycles after entering RAMP.
- Target = 0: IDLE→(DELAY)→RAMP, then on the first cycle in RAMP go to HOLD with a ramp_done pulse; gain stays 0.
- HOLD: gain held, tx_active=1. Changes on the configuration inputs are ignored until the next start.
- tx_en low in DELAY, RAMP or HOLD:
  - Without the optional feature: next cycle gain=0, state IDLE, no ramp_done.
- Simultaneous tx_en fall and step tick: the fall wins.
- Simultaneous start_evt and tx_en=0: no start.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
RAMP_DOWN_EN.
- Defined:
  - A tx_en fall in RAMP or HOLD enters state RAMPDN, with int_cnt reloaded from the latched interval.
  - On each tick: gain <= max(gain-step, 0), computed saturating.
  - When gain reaches 0: go to IDLE.
  - ramp_busy=1 during RAMPDN. start_evt is ignored during RAMPDN. tx_en rising again does not abort the ramp-down.
  - A tx_en fall in DELAY still goes straight to IDLE, since gain is already 0.
  - Reset still clears to 0 immediately.
- Undefined: RAMPDN does not exist; the gain drops to 0 on the next cycle.

Test Plan:
1. Reset, then tx_en=1, tx_start 0→1 with target=40, step=8, interval=3, delay=2 → DELAY lasts 2 cycles; gain 8,16,24,32,40, each held 4 cycles; ramp_done single pulse with gain=40; tx_active=1.
2. target=20, step=8, interval=0, delay=0 → gain 8,16,20 on consecutive cycles; no overshoot; done at 20. Also target=63, step=15: 15,30,45,60,63 with no wrap.
3. Mid-RAMP (gain=16), tx_en→0 → next cycle gain=0, IDLE, no ramp_done. With RAMP_DOWN_EN and step=8, interval=1: gain 8 then 0, two cycles apart, then IDLE.
4. tx_start held high for 50 cycles, and tx_start pulsed again during HOLD → exactly one ramp; the second pulse is ignored. Also gain_step=0 → ramps by 1.
5. converter_reset_n low for 1 cycle mid-RAMP (gain=24) → next edge: gain=0, all flags 0, IDLE; a fresh start ramps normally.
6. target=0 → ramp_done pulse after delay+1 cycles, gain stays 0, tx_active=1.
